// File: rtl/instr_pkg.sv
// Opcodes, format codes and NOP word shared by the RV32I field encoder and its packer.
// Building with INSTR_ENC_JAL_EN makes the UJ (jal) opcode a legal format.
package instr_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_IMM = 7'b0010011;
    localparam logic [6:0] OP_I_LW  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_SB    = 7'b1100011;
    localparam logic [6:0] OP_UJ    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_SB,
        FMT_UJ,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t fmt_of(input logic [6:0] op);
        fmt_t f;
        case (op)
            OP_R:              f = FMT_R;
            OP_I_IMM, OP_I_LW: f = FMT_I;
            OP_S:              f = FMT_S;
            OP_SB:             f = FMT_SB;
`ifdef INSTR_ENC_JAL_EN
            OP_UJ:             f = FMT_UJ;
`endif
            default:           f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: format + decoded fields -> 32-bit RV32I word; FMT_BAD yields NOP.
// Zero latency, no handshake. UJ packing exists only with INSTR_ENC_JAL_EN.
module instr_pack
    import instr_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst
);

`ifdef INSTR_ENC_JAL_EN
    logic unused_imm;
    assign unused_imm = ^imm[31:20];
`else
    logic unused_imm;
    assign unused_imm = ^imm[31:12];
`endif

    // SB and UJ immediates arrive in halfword units, so imm[k] is byte-offset bit k+1.
    always_comb begin
        inst = NOP;
        case (fmt)
            FMT_R:  inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:  inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:  inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_SB: inst = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
`ifdef INSTR_ENC_JAL_EN
            FMT_UJ: inst = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
`endif
            default: inst = NOP;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage encoder: stage 1 registers fields and range-checks, stage 2 packs and tags a word address.
// Latency 2 cycles, 1 word/cycle; in_ready_o falls only when both stages hold words. Macro: INSTR_ENC_JAL_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          inst_o,
    output logic [ADDR_W-1:0]    addr_o,
    output logic                 err_o,
    input  logic                 addr_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    fmt_t        in_fmt;
    logic        fits12;

    logic        s1_valid;
    fmt_t        s1_fmt;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [31:0] s1_imm;

    logic              s2_adv;
    logic              s2_load;
    logic              s1_load;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       packed_word;

    // A value fits a signed field when every bit above the field's sign bit matches it.
    assign fits12 = (&imm_i[31:11]) || !(|imm_i[31:11]);

`ifdef INSTR_ENC_JAL_EN
    logic fits20;
    assign fits20 = (&imm_i[31:19]) || !(|imm_i[31:19]);
`endif

    always_comb begin
        in_fmt = fmt_of(opcode_i);
        case (in_fmt)
            FMT_I, FMT_S, FMT_SB: if (!fits12) in_fmt = FMT_BAD;
`ifdef INSTR_ENC_JAL_EN
            FMT_UJ:               if (!fits20) in_fmt = FMT_BAD;
`endif
            default: ;
        endcase
    end

    assign s2_adv     = !out_valid_o || out_ready_i;
    assign s2_load    = s1_valid && s2_adv;
    assign in_ready_o = !s1_valid || s2_adv;
    assign s1_load    = in_valid_i && in_ready_o;
    assign load_addr  = addr_clr_i ? '0 : addr_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid <= 1'b0;
            s1_fmt   <= FMT_R;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_f7    <= '0;
            s1_imm   <= '0;
        end else begin
            if (in_ready_o) s1_valid <= in_valid_i;
            if (s1_load) begin
                s1_fmt <= in_fmt;
                s1_op  <= opcode_i;
                s1_rd  <= rd_i;
                s1_rs1 <= rs1_i;
                s1_rs2 <= rs2_i;
                s1_f3  <= funct3_i;
                s1_f7  <= funct7_i;
                s1_imm <= imm_i;
            end
        end
    end

    instr_pack u_pack (
        .fmt    (s1_fmt),
        .opcode (s1_op),
        .rd     (s1_rd),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .funct3 (s1_f3),
        .funct7 (s1_f7),
        .imm    (s1_imm),
        .inst   (packed_word)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_o <= 1'b0;
            inst_o      <= '0;
            addr_o      <= '0;
            err_o       <= 1'b0;
        end else begin
            if (s2_adv) out_valid_o <= s1_valid;
            if (s2_load) begin
                inst_o <= packed_word;
                addr_o <= load_addr;
                err_o  <= (s1_fmt == FMT_BAD);
            end
        end
    end

    // A clear coinciding with a load gives that word address 0 and leaves the counter at 1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_cnt <= '0;
        end else if (s2_load) begin
            addr_cnt <= load_addr + ADDR_W'(1);
        end else if (addr_clr_i) begin
            addr_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i && err_o && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded bench for instr_encoder: directed test-plan cases, back-pressure, clear, reset and random traffic.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [7:0]  addr;
    logic        err;
    logic        addr_clr;
    logic [7:0]  err_cnt;

    instr_encoder #(.ADDR_W(8), .ERR_CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .opcode_i    (opcode),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .imm_i       (imm),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .inst_o      (inst),
        .addr_o      (addr),
        .err_o       (err),
        .addr_clr_i  (addr_clr),
        .err_cnt_o   (err_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          next_addr = 0;
    int          model_err = 0;
    int          rdy_mode = 0;
    logic [31:0] last_inst;
    logic [7:0]  last_addr;
    logic        last_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RISC-V encoding rules from byte offsets, independent of the RTL bit layout.
    function automatic bit is_legal(input logic [6:0] op, input int v);
        case (op)
            7'b0110011: return 1'b1;
            7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011: return (v >= -2048) && (v <= 2047);
`ifdef INSTR_ENC_JAL_EN
            7'b1101111: return (v >= -524288) && (v <= 524287);
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                            input int v);
        int off;
        int base;
        int w;
        off  = v * 2;
        base = int'(op) | (int'(f3) << 12) | (int'(s1) << 15);
        w    = 32'h13;
        if (is_legal(op, v)) begin
            case (op)
                7'b0110011: w = base | (int'(d) << 7) | (int'(s2) << 20) | (int'(f7) << 25);
                7'b0100011: w = base | (int'(s2) << 20) | ((v & 31) << 7) | (((v >>> 5) & 127) << 25);
                7'b1100011: w = base | (int'(s2) << 20) | (((off >>> 1) & 15) << 8) | (((off >>> 11) & 1) << 7)
                                | (((off >>> 5) & 63) << 25) | (((off >>> 12) & 1) << 31);
                7'b1101111: w = int'(op) | (int'(d) << 7) | (((off >>> 12) & 255) << 12)
                                | (((off >>> 11) & 1) << 20) | (((off >>> 1) & 1023) << 21)
                                | (((off >>> 20) & 1) << 31);
                default:    w = base | (int'(d) << 7) | ((v & 4095) << 20);
            endcase
        end
        return w;
    endfunction

    function automatic int sb_decode(input logic [31:0] word);
        int w;
        int off;
        w   = int'(word);
        off = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
        if (off >= 4096) off = off - 8192;
        return off / 2;
    endfunction

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input int v, input bit clr_load);
        bit   acc;
        int   n;
        exp_t e;
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            e.inst    = ref_enc(op, d, s1, s2, f3, f7, v);
            e.err     = !is_legal(op, v);
            e.addr    = clr_load ? 8'd0 : 8'(next_addr);
            next_addr = (int'(e.addr) + 1) % 256;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words still pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold stability under stall.
    initial begin
        exp_t        e;
        bit          prev_hold;
        logic [31:0] p_inst;
        logic [7:0]  p_addr;
        logic        p_err;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_inst", inst, p_inst);
                    chk("hold_addr", 32'(addr), 32'(p_addr));
                    chk("hold_err", 32'(err), 32'(p_err));
                end
                if (out_valid) chk("err_cnt", 32'(err_cnt), 32'(model_err));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got inst %h addr %0d, expected no output", inst, addr);
                    end else begin
                        e = sb.pop_front();
                        chk("inst", inst, e.inst);
                        chk("addr", 32'(addr), 32'(e.addr));
                        chk("err", 32'(err), 32'(e.err));
                        if (e.err && model_err < 255) model_err++;
                    end
                    last_inst = inst;
                    last_addr = addr;
                    last_err  = err;
                end
                prev_hold = out_valid && !out_ready;
                p_inst = inst;
                p_addr = addr;
                p_err  = err;
            end
        end
    end

    initial begin
        logic [6:0] ops [7];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1111111};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_clr = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        #15;
        rst_n = 1'b1;

        // addi with latency check
        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -1, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        drain();
        chk("addi_inst", last_inst, 32'hFFF10093);
        chk("addi_addr", 32'(last_addr), 32'd0);

        send(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 40, 1'b0);
        drain();
        chk("sw_inst", last_inst, 32'h02512423);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -2, 1'b0);
        drain();
        chk("beq_inst", last_inst, 32'hFE208EE3);
        chk("beq_roundtrip", 32'(sb_decode(last_inst)), 32'(-2));

        send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 2048, 1'b0);
        drain();
        chk("imm2048_inst", last_inst, 32'h00000013);
        chk("imm2048_err", 32'(last_err), 32'd1);
        chk("imm2048_cnt", 32'(err_cnt), 32'd1);
        send(7'b1111111, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 5, 1'b0);
        drain();
        chk("badop_inst", last_inst, 32'h00000013);
        chk("badop_cnt", 32'(err_cnt), 32'd2);

        // streaming under back-pressure
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        next_addr = 0;
        send(7'b0110011, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 0, 1'b0);
        send(7'b0010011, 5'd7, 5'd8, 5'd9, 3'd3, 7'd0, 100, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        fork
            begin
                send(7'b0000011, 5'd10, 5'd11, 5'd0, 3'd2, 7'd0, -2048, 1'b0);
                send(7'b0100011, 5'd0, 5'd12, 5'd13, 3'd0, 7'd0, 2047, 1'b0);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                rdy_mode = 0;
            end
        join
        drain();
        chk("stream_last_addr", 32'(last_addr), 32'd3);

        // reset with two words in flight
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 1, 1'b0);
        send(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 2, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        next_addr = 0;
        model_err = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(7'b0010011, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 7, 1'b0);
        drain();
        chk("post_rst_addr", 32'(last_addr), 32'd0);

        // clear coinciding with the third word's stage-2 load
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        next_addr = 0;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 10, 1'b0);
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 11, 1'b0);
        send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 12, 1'b1);
        addr_clr = 1'b1;
        send(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 13, 1'b0);
        addr_clr = 1'b0;
        drain();
        chk("clr_last_addr", 32'(last_addr), 32'd1);

        // saturation of the error counter, also wraps the address counter
        for (int i = 0; i < 260; i++) send(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, i, 1'b0);
        drain();
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        // random traffic with random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int         k;
            int         v;
            logic [6:0] op;
            k  = int'($urandom_range(0, 6));
            op = (k == 6) ? 7'($urandom) : ops[k];
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 4095)) - 2048;
                1: v = (int'($urandom_range(0, 1)) == 1) ? 2047 + int'($urandom_range(0, 1))
                                                           : -2048 - int'($urandom_range(0, 1));
                2: v = int'($urandom);
                default: v = int'($urandom_range(0, 1048575)) - 524288;
            endcase
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), v, 1'b0);
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
